cache_line_refill_axi: RTL and testbench
========================================

// Module: cache_line_refill_axi
// PURPOSE: Downstream memory-side stage of the direct-mapped cache. On a miss the cache control FSM
//   hands it a line address. It fetches the whole line over AXI4-Lite as WORDS single-word reads,
//   with up to MAX_OUTSTANDING reads in flight. It streams each returned word, tagged with its
//   word index, into the cache data array and reports one aggregated response per line.
// PARAMETERS:
//   ADDR_WIDTH       32  byte-address width (fill_req_addr, araddr)
//   DATA_WIDTH       32  AXI data width; BPW = DATA_WIDTH/8 bytes per word
//   LINE_BYTES       16  cache line size; WORDS = LINE_BYTES/BPW (power of 2, >=1)
//   MAX_OUTSTANDING  2   max AR accepted but R not yet received (1..WORDS)
// PORTS:
//   clk             in   1                clock, all logic on rising edge
//   rst             in   1                asynchronous, active-high reset
//   fill_req_valid  in   1                FSM requests a line refill
//   fill_req_ready  out  1                engine idle, can accept a request
//   fill_req_addr   in   ADDR_WIDTH       any byte address inside the line to fetch
//   fill_word_valid out  1                one-cycle pulse: fill_word_data is valid
//   fill_word_idx   out  $clog2(WORDS)    word index within line (0..WORDS-1); width 1 when WORDS=1
//   fill_word_data  out  DATA_WIDTH       returned word
//   fill_done       out  1                one-cycle pulse: line complete
//   fill_resp       out  2                aggregated line response, valid with fill_done
//   araddr          out  ADDR_WIDTH       AXI read address
//   arvalid         out  1                AXI read address valid
//   arready         in   1                AXI read address ready
//   rdata           in   DATA_WIDTH       AXI read data
//   rresp           in   2                AXI read response
//   rvalid          in   1                AXI read data valid
//   rready          out  1                AXI read data ready
// BEHAVIOUR:
// - Reset (async, while rst=1): state=IDLE; all outputs 0, including fill_req_ready, counters and
//   sticky response. On the first clock edge after release: fill_req_ready=1.
// - States: IDLE, FILL.
// - IDLE
//   - fill_req_ready=1.
//   - On fill_req_valid & fill_req_ready: base = fill_req_addr with low $clog2(LINE_BYTES) bits cleared.
//   - Clear ar_cnt, r_cnt, outstanding and sticky resp, then go to FILL.
//   - First arvalid rises in the next cycle, giving 1-cycle accept->AR latency.
// - FILL
//   - fill_req_ready=0; rready=1 continuously.
//   - arvalid=1 while ar_cnt<WORDS and outstanding<MAX_OUTSTANDING.
//   - araddr = base + ar_cnt*BPW, computed mod 2^ADDR_WIDTH; no wrap past the line, since base is aligned.
//   - Once arvalid=1, it and araddr stay stable until arready; arvalid never depends combinationally on rvalid.
//   - AR handshake: ar_cnt++, outstanding++.
//   - R handshake: outstanding--, r_cnt++. Same-cycle AR and R handshakes leave outstanding unchanged.
//   - R data arrives in issue order.
//   - On each R handshake, in the next cycle: fill_word_valid=1, fill_word_idx=r_cnt (pre-increment),
//     fill_word_data=rdata.
//   - Sticky resp: first non-OKAY rresp is held; later errors do not overwrite it.
//   - Error beats are still delivered; the FSM invalidates the line on fill_resp!=0. Remaining reads are
//     not cancelled.
//   - fill_done and fill_resp are asserted in the same cycle as the last fill_word_valid (idx=WORDS-1).
//   - In that cycle the state returns to IDLE; fill_req_ready=1 in the following cycle.
// - fill_word_valid, fill_done: single-cycle pulses, 0 otherwise. fill_word_data/idx hold their last value.
// - Reset mid-FILL: aborts immediately. In-flight R beats are not tracked; the AXI slave shares the same reset.
// - fill_req_valid while in FILL: ignored, not queued.
// TESTING:
// 1. Hold rst=1 -> all outputs 0. Release -> fill_req_ready=1 one edge later, arvalid=0.
// 2. LINE_BYTES=16, fill_req_addr=0x0000_1234, zero-wait slave ->
//    - AR addresses 0x1230, 0x1234, 0x1238, 0x123C;
//    - fill_word_idx 0..3 in order with matching rdata;
//    - fill_done with fill_resp=2'b00;
//    - fill_req_ready=1 next cycle.
// 3. MAX_OUTSTANDING=2, slave delays first rvalid 5 cycles -> exactly 2 AR accepted before the first R;
//    the 3rd arvalid only rises after an R handshake.
// 4. arready=0 for 10 cycles on beat 0 -> arvalid held high, araddr=0x1230 stable throughout.
// 5. rresp=2'b10 on beat 1, 2'b11 on beat 3 -> all 4 fill_word_valid pulses, fill_resp=2'b10 at fill_done.
// 6. Assert rst after 2 words delivered -> outputs 0 asynchronously. After release, a new request at
//    0x2000 starts at idx 0 with araddr 0x2000.

Source files
------------

// File: rtl/cache_line_refill_axi.sv
// Cache line refill engine: fetches one cache line over AXI4-Lite as a
// sequence of single-word reads with a bounded number in flight, streams
// each returned word with its index into the data array, and reports one
// aggregated response when the line is complete.
//
// Handshake semantics (all channels): a transfer happens on a rising clock
// edge where valid and ready are both 1. Once this block raises a valid, the
// valid and its payload stay stable until the matching ready is seen.
// This block's valid outputs never depend combinationally on the partner's
// ready, and rready does not depend on rvalid.
module cache_line_refill_axi #(
    parameter  int ADDR_WIDTH      = 32,
    parameter  int DATA_WIDTH      = 32,
    parameter  int LINE_BYTES      = 16,
    parameter  int MAX_OUTSTANDING = 2,
    localparam int BPW             = DATA_WIDTH / 8,
    localparam int WORDS           = LINE_BYTES / BPW,
    localparam int IDX_W           = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fill_req_valid,
    output logic                  fill_req_ready,
    input  logic [ADDR_WIDTH-1:0] fill_req_addr,
    output logic                  fill_word_valid,
    output logic [IDX_W-1:0]      fill_word_idx,
    output logic [DATA_WIDTH-1:0] fill_word_data,
    output logic                  fill_done,
    output logic [1:0]            fill_resp,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,
    output logic                  state_dbg
);

    localparam int CNT_W = $clog2(WORDS + 1);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [CNT_W-1:0]      WORDS_C   = CNT_W'(WORDS);
    localparam logic [CNT_W-1:0]      LAST_C    = CNT_W'(WORDS - 1);
    localparam logic [OUT_W-1:0]      MAX_OUT_C = OUT_W'(MAX_OUTSTANDING);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] BPW_C     = ADDR_WIDTH'(BPW);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] base;
    logic [CNT_W-1:0]      ar_cnt;
    logic [CNT_W-1:0]      r_cnt;
    logic [OUT_W-1:0]      outstanding;
    logic [1:0]            resp_sticky;
    logic                  accept;
    logic                  ar_hs;
    logic                  r_hs;
    logic                  last_beat;

    // Next-state logic and the combinational AXI controls.
    always_comb begin
        state_nxt = state;
        arvalid   = 1'b0;
        rready    = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                accept = fill_req_valid && fill_req_ready;
                if (accept) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                rready = 1'b1;
                // Only registered counters feed arvalid, so it cannot
                // drop before arready: outstanding can only shrink meanwhile.
                arvalid = (ar_cnt < WORDS_C) && (outstanding < MAX_OUT_C);
                if (rvalid && (r_cnt == LAST_C)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ar_hs     = arvalid && arready;
    assign r_hs      = rvalid && rready;
    assign last_beat = r_hs && (r_cnt == LAST_C);
    // Base is line aligned, so the offset never carries out of the line.
    assign araddr    = base + (ADDR_WIDTH'(ar_cnt) * BPW_C);
    assign state_dbg = (state == FILL);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request ready: registered so it is 0 in reset and in the done cycle,
    // and rises one edge after the engine has settled in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_req_ready <= 1'b0;
        end else begin
            fill_req_ready <= (state == IDLE) && (state_nxt == IDLE);
        end
    end

    // Line base, issue/return counters, in-flight count and sticky response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base        <= '0;
            ar_cnt      <= '0;
            r_cnt       <= '0;
            outstanding <= '0;
            resp_sticky <= 2'b00;
        end else if (accept) begin
            base        <= fill_req_addr & LINE_MASK;
            ar_cnt      <= '0;
            r_cnt       <= '0;
            outstanding <= '0;
            resp_sticky <= 2'b00;
        end else begin
            if (ar_hs) begin
                ar_cnt <= ar_cnt + CNT_W'(1);
            end
            if (r_hs) begin
                r_cnt <= r_cnt + CNT_W'(1);
                // The first error wins; later errors are ignored.
                if (resp_sticky == 2'b00) begin
                    resp_sticky <= rresp;
                end
            end
            case ({ar_hs, r_hs})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Word stream and line completion pulses, one cycle after each R beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_word_valid <= 1'b0;
            fill_word_idx   <= '0;
            fill_word_data  <= '0;
            fill_done       <= 1'b0;
            fill_resp       <= 2'b00;
        end else begin
            fill_word_valid <= r_hs;
            fill_done       <= last_beat;
            if (r_hs) begin
                fill_word_idx  <= r_cnt[IDX_W-1:0];
                fill_word_data <= rdata;
            end
            if (last_beat) begin
                fill_resp <= (resp_sticky != 2'b00) ? resp_sticky : rresp;
            end
        end
    end

endmodule

// File: tb/tb_cache_line_refill_axi.sv
// Bench for the cache line refill engine: an AXI4-Lite slave with
// programmable stalls and error responses, a monitor that records what the
// engine emits, a line-level reference model and one task per scenario.
module tb_cache_line_refill_axi;

    localparam int ADDR_WIDTH      = 32;
    localparam int DATA_WIDTH      = 32;
    localparam int LINE_BYTES      = 16;
    localparam int MAX_OUTSTANDING = 2;
    localparam int BPW             = DATA_WIDTH / 8;
    localparam int WORDS           = LINE_BYTES / BPW;
    localparam int IDX_W           = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic                  clk;
    logic                  rst;
    logic                  fill_req_valid;
    logic                  fill_req_ready;
    logic [ADDR_WIDTH-1:0] fill_req_addr;
    logic                  fill_word_valid;
    logic [IDX_W-1:0]      fill_word_idx;
    logic [DATA_WIDTH-1:0] fill_word_data;
    logic                  fill_done;
    logic [1:0]            fill_resp;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;
    logic                  state_dbg;

    cache_line_refill_axi #(
        .ADDR_WIDTH      (ADDR_WIDTH),
        .DATA_WIDTH      (DATA_WIDTH),
        .LINE_BYTES      (LINE_BYTES),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .fill_req_valid  (fill_req_valid),
        .fill_req_ready  (fill_req_ready),
        .fill_req_addr   (fill_req_addr),
        .fill_word_valid (fill_word_valid),
        .fill_word_idx   (fill_word_idx),
        .fill_word_data  (fill_word_data),
        .fill_done       (fill_done),
        .fill_resp       (fill_resp),
        .araddr          (araddr),
        .arvalid         (arvalid),
        .arready         (arready),
        .rdata           (rdata),
        .rresp           (rresp),
        .rvalid          (rvalid),
        .rready          (rready),
        .state_dbg       (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- bench state ----------------
    int n_checks = 0;
    int n_pass   = 0;

    int ar_ready_pct = 100;
    int r_pct        = 100;
    int ar_stall     = 0;
    int r_hold_left  = 0;
    logic [1:0] resp_plan [WORDS];
    logic [DATA_WIDTH-1:0] salt;

    logic [ADDR_WIDTH-1:0] r_q[$];
    int   r_beat;
    int   osd;
    logic r_hold_beat;
    logic ar_waiting;
    logic [ADDR_WIDTH-1:0] ar_wait_addr;
    logic prev_done;

    int acc_cnt, ar_total, r_total, ar_before_r, over_limit, ar_unstable, stall_cycles;
    logic [ADDR_WIDTH-1:0] stall_addr;

    logic [ADDR_WIDTH-1:0] got_ar[$];
    logic [IDX_W-1:0]      got_idx[$];
    logic [DATA_WIDTH-1:0] got_data[$];
    logic [1:0]            got_resp[$];
    logic                  got_sync[$];
    logic                  got_ready_after[$];

    // Scoreboard expectations for the current line.
    logic [DATA_WIDTH-1:0] exp_q[$];
    logic [ADDR_WIDTH-1:0] exp_ar_q[$];
    logic [1:0]            exp_resp;

    // Slave memory contents: a fixed scramble of the word address.
    function automatic logic [DATA_WIDTH-1:0] mem_word(input logic [ADDR_WIDTH-1:0] a);
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    // Line-level reference: which addresses, which words, which response.
    task automatic model_line(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] line_base;
        line_base = a - (a % LINE_BYTES);
        exp_q.delete();
        exp_ar_q.delete();
        exp_resp = 2'b00;
        for (int i = 0; i < WORDS; i++) begin
            exp_ar_q.push_back(line_base + ADDR_WIDTH'(i * BPW));
            exp_q.push_back(mem_word(line_base + ADDR_WIDTH'(i * BPW)));
            if (exp_resp == 2'b00) exp_resp = resp_plan[i];
        end
    endtask

    task automatic clear_obs();
        got_ar.delete();
        got_idx.delete();
        got_data.delete();
        got_resp.delete();
        got_sync.delete();
        got_ready_after.delete();
        acc_cnt = 0; ar_total = 0; r_total = 0; ar_before_r = -1;
        over_limit = 0; ar_unstable = 0; stall_cycles = 0; stall_addr = '0;
    endtask

    // ---------------- AXI slave + monitor ----------------
    // Inputs change on the falling edge; outputs are observed 1 unit later,
    // which tells what will transfer on the next rising edge.
    initial begin : bus_model
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
        r_beat = 0; osd = 0; r_hold_beat = 1'b0; ar_waiting = 1'b0; prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                arready = 1'b0; rvalid = 1'b0;
                r_q.delete(); r_beat = 0; osd = 0; r_hold_left = 0;
                r_hold_beat = 1'b0; ar_waiting = 1'b0; prev_done = 1'b0;
            end else begin
                if (ar_stall > 0) begin
                    arready = 1'b0;
                    ar_stall--;
                end else begin
                    arready = (int'($urandom_range(99)) < ar_ready_pct);
                end
                if (!r_hold_beat) begin
                    rvalid = 1'b0;
                    if (r_q.size() > 0) begin
                        if (r_hold_left > 0) r_hold_left--;
                        else if (int'($urandom_range(99)) < r_pct) begin
                            rvalid = 1'b1;
                            rdata  = mem_word(r_q[0]);
                            rresp  = resp_plan[r_beat];
                        end
                    end
                end
                #1;
                if (fill_req_valid && fill_req_ready) acc_cnt++;
                if (ar_waiting && (!arvalid || araddr !== ar_wait_addr)) ar_unstable++;
                ar_waiting   = arvalid && !arready;
                ar_wait_addr = araddr;
                if (arvalid && !arready) begin
                    stall_cycles++;
                    stall_addr = araddr;
                end
                if (arvalid && osd >= MAX_OUTSTANDING) over_limit++;
                if (rvalid && rready) begin
                    if (r_total == 0) ar_before_r = ar_total;
                    r_total++;
                    r_q.delete(0);
                    osd--;
                    r_beat = (r_beat + 1) % WORDS;
                end
                if (arvalid && arready) begin
                    got_ar.push_back(araddr);
                    r_q.push_back(araddr);
                    osd++;
                    ar_total++;
                end
                r_hold_beat = rvalid && !rready;
                if (prev_done) got_ready_after.push_back(fill_req_ready);
                prev_done = fill_done;
                if (fill_word_valid) begin
                    got_idx.push_back(fill_word_idx);
                    got_data.push_back(fill_word_data);
                end
                if (fill_done) begin
                    got_resp.push_back(fill_resp);
                    got_sync.push_back(fill_word_valid && (fill_word_idx == IDX_W'(WORDS - 1))
                                       && !fill_req_ready);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_req(input logic [ADDR_WIDTH-1:0] a, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        fill_req_valid = 1'b1;
        fill_req_addr  = a;
        for (int t = 0; t < 50 && !ok; t++) begin
            #2;
            if (fill_req_ready) ok = 1'b1;
            else @(negedge clk);
        end
        @(negedge clk);
        fill_req_valid = 1'b0;
    endtask

    task automatic wait_done(input int n, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk);
            #2;
            if (got_resp.size() >= n) ok = 1'b1;
        end
        @(negedge clk);
        #2;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        fill_req_valid = 1'b0;
        fill_req_addr  = '0;
        repeat (3) @(negedge clk);
        #2;
        n_checks++;
        if ({fill_req_ready, arvalid, rready, fill_word_valid, fill_done, state_dbg} !== 6'b0)
            $display("FAIL reset_ctrl got=%b exp=000000",
                     {fill_req_ready, arvalid, rready, fill_word_valid, fill_done, state_dbg});
        else n_pass++;
        n_checks++;
        if ({araddr, fill_word_idx, fill_word_data, fill_resp} !== '0)
            $display("FAIL reset_data araddr=%h idx=%0d data=%h resp=%0d exp=all zero",
                     araddr, fill_word_idx, fill_word_data, fill_resp);
        else n_pass++;
        @(negedge clk);
        #3 rst = 1'b0;
        #1;
        n_checks++;
        if (fill_req_ready !== 1'b0) $display("FAIL release_no_edge got=%b exp=0", fill_req_ready);
        else n_pass++;
        @(negedge clk);
        #2;
        n_checks++;
        if ({fill_req_ready, arvalid} !== 2'b10)
            $display("FAIL release_ready got ready=%b arvalid=%b exp ready=1 arvalid=0",
                     fill_req_ready, arvalid);
        else n_pass++;
    endtask

    task automatic test_basic();
        bit ok;
        clear_obs();
        ar_ready_pct = 100; r_pct = 100;
        for (int i = 0; i < WORDS; i++) resp_plan[i] = 2'b00;
        model_line(32'h0000_1234);
        send_req(32'h0000_1234, ok);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL basic_accept got=%b exp=1", ok); else n_pass++;
        wait_done(1, ok);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL basic_done got=timeout exp=fill_done"); else n_pass++;
        n_checks++;
        if (got_ar.size() != WORDS) $display("FAIL basic_ar_count got=%0d exp=%0d", got_ar.size(), WORDS);
        else n_pass++;
        n_checks++;
        if (got_ar.size() > 0 && got_ar[0] !== 32'h0000_1230)
            $display("FAIL basic_first_araddr got=%h exp=00001230", got_ar[0]);
        else n_pass++;
        for (int i = 0; i < WORDS && i < got_ar.size(); i++) begin
            n_checks++;
            if (got_ar[i] !== exp_ar_q[i]) $display("FAIL basic_araddr[%0d] got=%h exp=%h", i, got_ar[i], exp_ar_q[i]);
            else n_pass++;
        end
        n_checks++;
        if (got_data.size() != WORDS) $display("FAIL basic_word_count got=%0d exp=%0d", got_data.size(), WORDS);
        else n_pass++;
        for (int i = 0; i < WORDS && i < got_data.size(); i++) begin
            n_checks++;
            if (got_idx[i] !== IDX_W'(i) || got_data[i] !== exp_q[i])
                $display("FAIL basic_word[%0d] got idx=%0d data=%h exp idx=%0d data=%h",
                         i, got_idx[i], got_data[i], i, exp_q[i]);
            else n_pass++;
        end
        n_checks++;
        if (got_resp.size() == 0 || got_resp[0] !== 2'b00 || got_sync[0] !== 1'b1)
            $display("FAIL basic_done_resp got=%p sync=%p exp resp=0 with last word", got_resp, got_sync);
        else n_pass++;
        n_checks++;
        if (got_ready_after.size() == 0 || got_ready_after[0] !== 1'b1)
            $display("FAIL basic_ready_after got=%p exp=1", got_ready_after);
        else n_pass++;
    endtask

    task automatic test_outstanding();
        bit ok;
        int bad;
        clear_obs();
        ar_ready_pct = 100; r_pct = 100; r_hold_left = 5;
        for (int i = 0; i < WORDS; i++) resp_plan[i] = 2'b00;
        model_line(32'h0000_1234);
        send_req(32'h0000_1234, ok);
        wait_done(1, ok);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL outst_done got=timeout exp=fill_done"); else n_pass++;
        n_checks++;
        if (ar_before_r !== MAX_OUTSTANDING)
            $display("FAIL outst_ar_before_r got=%0d exp=%0d", ar_before_r, MAX_OUTSTANDING);
        else n_pass++;
        n_checks++;
        if (over_limit !== 0) $display("FAIL outst_arvalid_over_limit got=%0d exp=0", over_limit);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < WORDS; i++)
            if (i >= got_data.size() || got_data[i] !== exp_q[i] || got_idx[i] !== IDX_W'(i)) bad++;
        n_checks++;
        if (bad !== 0 || got_data.size() != WORDS)
            $display("FAIL outst_words got bad=%0d count=%0d exp bad=0 count=%0d", bad, got_data.size(), WORDS);
        else n_pass++;
    endtask

    task automatic test_ar_stall();
        bit ok;
        int bad;
        clear_obs();
        ar_ready_pct = 100; r_pct = 100; ar_stall = 12;
        for (int i = 0; i < WORDS; i++) resp_plan[i] = 2'b00;
        model_line(32'h0000_1234);
        send_req(32'h0000_1234, ok);
        wait_done(1, ok);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL stall_done got=timeout exp=fill_done"); else n_pass++;
        n_checks++;
        if (stall_cycles < 10) $display("FAIL stall_cycles got=%0d exp>=10", stall_cycles); else n_pass++;
        n_checks++;
        if (stall_addr !== 32'h0000_1230) $display("FAIL stall_araddr got=%h exp=00001230", stall_addr);
        else n_pass++;
        n_checks++;
        if (ar_unstable !== 0) $display("FAIL stall_ar_unstable got=%0d exp=0", ar_unstable); else n_pass++;
        bad = 0;
        for (int i = 0; i < WORDS; i++)
            if (i >= got_ar.size() || got_ar[i] !== exp_ar_q[i] || i >= got_data.size() || got_data[i] !== exp_q[i]) bad++;
        n_checks++;
        if (bad !== 0) $display("FAIL stall_line got bad=%0d exp=0", bad); else n_pass++;
    endtask

    task automatic test_error_resp();
        bit ok;
        clear_obs();
        ar_ready_pct = 100; r_pct = 100;
        resp_plan[0] = 2'b00; resp_plan[1] = 2'b10; resp_plan[2] = 2'b00; resp_plan[3] = 2'b11;
        model_line(32'h0000_1234);
        send_req(32'h0000_1234, ok);
        wait_done(1, ok);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL err_done got=timeout exp=fill_done"); else n_pass++;
        n_checks++;
        if (got_data.size() != WORDS) $display("FAIL err_word_count got=%0d exp=%0d", got_data.size(), WORDS);
        else n_pass++;
        n_checks++;
        if (got_resp.size() == 0 || got_resp[0] !== 2'b10 || got_resp[0] !== exp_resp)
            $display("FAIL err_resp got=%p exp=%0d", got_resp, exp_resp);
        else n_pass++;
        n_checks++;
        if (got_sync.size() == 0 || got_sync[0] !== 1'b1) $display("FAIL err_done_sync got=%p exp=1", got_sync);
        else n_pass++;
        for (int i = 0; i < WORDS; i++) resp_plan[i] = 2'b00;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int bad;
        clear_obs();
        ar_ready_pct = 100; r_pct = 35;
        for (int i = 0; i < WORDS; i++) resp_plan[i] = 2'b00;
        send_req(32'h0000_5670, ok);
        ok = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            #2;
            if (got_data.size() >= 2) ok = 1'b1;
        end
        n_checks++;
        if (ok !== 1'b1) $display("FAIL rstmid_two_words got=%0d exp>=2", got_data.size()); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({fill_req_ready, arvalid, rready, fill_word_valid, fill_done, state_dbg} !== 6'b0
            || fill_word_idx !== '0 || fill_word_data !== '0)
            $display("FAIL rstmid_outputs got ctrl=%b idx=%0d data=%h exp all zero",
                     {fill_req_ready, arvalid, rready, fill_word_valid, fill_done, state_dbg},
                     fill_word_idx, fill_word_data);
        else n_pass++;
        repeat (2) @(negedge clk);
        #3 rst = 1'b0;
        r_pct = 100;
        clear_obs();
        model_line(32'h0000_2000);
        send_req(32'h0000_2000, ok);
        wait_done(1, ok);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL rstmid_done got=timeout exp=fill_done"); else n_pass++;
        n_checks++;
        if (got_ar.size() == 0 || got_ar[0] !== 32'h0000_2000)
            $display("FAIL rstmid_first_araddr got=%p exp=00002000", got_ar);
        else n_pass++;
        n_checks++;
        if (got_idx.size() == 0 || got_idx[0] !== '0) $display("FAIL rstmid_first_idx got=%p exp=0", got_idx);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < WORDS; i++)
            if (i >= got_data.size() || got_data[i] !== exp_q[i] || got_idx[i] !== IDX_W'(i)) bad++;
        n_checks++;
        if (bad !== 0 || got_data.size() != WORDS)
            $display("FAIL rstmid_words got bad=%0d count=%0d exp bad=0 count=%0d", bad, got_data.size(), WORDS);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        int bad;
        logic [DATA_WIDTH-1:0] all_data[$];
        logic [ADDR_WIDTH-1:0] all_ar[$];
        clear_obs();
        ar_ready_pct = 100; r_pct = 100;
        for (int i = 0; i < WORDS; i++) resp_plan[i] = 2'b00;
        model_line(32'h0000_4008);
        all_data = exp_q; all_ar = exp_ar_q;
        model_line(32'h0000_8FFF);
        all_data = {all_data, exp_q}; all_ar = {all_ar, exp_ar_q};
        @(negedge clk);
        fill_req_valid = 1'b1;
        fill_req_addr  = 32'h0000_4008;
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            #2;
            if (acc_cnt >= 1) ok = 1'b1;
            else @(negedge clk);
        end
        @(negedge clk);
        fill_req_addr = 32'h0000_8FFF;
        ok = 1'b0;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk);
            #2;
            if (got_resp.size() >= 2) ok = 1'b1;
        end
        fill_req_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        n_checks++;
        if (ok !== 1'b1) $display("FAIL b2b_done got=%0d exp=2", got_resp.size()); else n_pass++;
        n_checks++;
        if (acc_cnt !== 2) $display("FAIL b2b_accepts got=%0d exp=2", acc_cnt); else n_pass++;
        bad = 0;
        for (int i = 0; i < 2 * WORDS; i++)
            if (i >= got_ar.size() || got_ar[i] !== all_ar[i] || i >= got_data.size()
                || got_data[i] !== all_data[i] || got_idx[i] !== IDX_W'(i % WORDS)) bad++;
        n_checks++;
        if (bad !== 0 || got_ar.size() != 2 * WORDS)
            $display("FAIL b2b_lines got bad=%0d ar_count=%0d exp bad=0 ar_count=%0d", bad, got_ar.size(), 2 * WORDS);
        else n_pass++;
    endtask

    task automatic test_random();
        bit ok;
        int bad;
        logic [ADDR_WIDTH-1:0] a;
        for (int line = 0; line < 25; line++) begin
            clear_obs();
            ar_ready_pct = $urandom_range(100, 30);
            r_pct        = $urandom_range(100, 30);
            for (int i = 0; i < WORDS; i++)
                resp_plan[i] = ($urandom_range(3) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
            a = $urandom;
            model_line(a);
            repeat ($urandom_range(3)) @(negedge clk);
            send_req(a, ok);
            wait_done(1, ok);
            bad = 0;
            for (int i = 0; i < WORDS; i++)
                if (i >= got_ar.size() || got_ar[i] !== exp_ar_q[i] || i >= got_data.size()
                    || got_data[i] !== exp_q[i] || got_idx[i] !== IDX_W'(i)) bad++;
            n_checks++;
            if (ok !== 1'b1 || bad !== 0 || got_data.size() != WORDS)
                $display("FAIL rand_line[%0d] addr=%h got bad=%0d words=%0d done=%b exp bad=0 words=%0d done=1",
                         line, a, bad, got_data.size(), ok, WORDS);
            else n_pass++;
            n_checks++;
            if (got_resp.size() == 0 || got_resp[0] !== exp_resp || got_sync[0] !== 1'b1)
                $display("FAIL rand_resp[%0d] got=%p sync=%p exp=%0d", line, got_resp, got_sync, exp_resp);
            else n_pass++;
            n_checks++;
            if (over_limit !== 0 || ar_unstable !== 0)
                $display("FAIL rand_ar_rules[%0d] got over=%0d unstable=%0d exp 0/0", line, over_limit, ar_unstable);
            else n_pass++;
        end
        ar_ready_pct = 100; r_pct = 100;
    endtask

    // ---------------- sequence ----------------
    initial begin : main
        rst = 1'b1;
        fill_req_valid = 1'b0;
        fill_req_addr = '0;
        salt = $urandom;
        for (int i = 0; i < WORDS; i++) resp_plan[i] = 2'b00;
        clear_obs();
        test_reset();
        test_basic();
        test_outstanding();
        test_ar_stall();
        test_error_resp();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
